// File: rtl/minibyte_pkg.sv
//------------------------------------------------------------------------------
// Module   : minibyte_pkg
// Purpose  : Shared fetch-sequencer constants: state encoding, opcode
//            immediate-flag bit, default memory timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package minibyte_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH_OP  = 3'd1;
    localparam logic [2:0] ST_FETCH_IMM = 3'd2;
    localparam logic [2:0] ST_ISSUE     = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_FETCH_OP  = ST_FETCH_OP,
        S_FETCH_IMM = ST_FETCH_IMM,
        S_ISSUE     = ST_ISSUE,
        S_FAULT     = ST_FAULT
    } state_t;

    // Opcodes with this bit set carry a one-byte immediate.
    localparam int unsigned IMM_FLAG_BIT           = 7;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 15;

endpackage

`default_nettype wire

// File: rtl/minibyte_fetch_timer.sv
//------------------------------------------------------------------------------
// Module   : minibyte_fetch_timer
// Purpose  : Memory wait counter; flags expiry on the wait cycle at which the
//            count reaches TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module minibyte_fetch_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic wait_i,
    output logic expired_o
);

    localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW     = (CW_RAW < 4) ? 4 : CW_RAW;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Any non-waiting cycle (ready, flush, state change) restarts the count.
    assign count_d   = wait_i ? (count_q + ONE) : '0;
    assign expired_o = wait_i && (count_q == LIMIT);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/minibyte_fetch.sv
//------------------------------------------------------------------------------
// Module   : minibyte_fetch
// Purpose  : minibyte instruction fetch sequencer (opcode + optional immediate).
//            Optional memory timeout fault: MINIBYTE_FETCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module minibyte_fetch
    import minibyte_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] pc_in,
    output logic       pc_inc_out,
    output logic [7:0] mem_addr_out,
    output logic       mem_req_out,
    input  logic [7:0] mem_rdata_in,
    input  logic       mem_ready_in,
    input  logic       flush_in,
    output logic [7:0] instr_opcode_out,
    output logic [7:0] instr_imm_out,
    output logic       instr_valid_out,
    input  logic       instr_ready_in,
    output logic       fault_out
);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] opcode_q;
    logic [7:0] imm_q;
    logic [7:0] imm_d;
    logic       opcode_en;
    logic       imm_en;
    logic       w_timeout;

    // Strobes are decoded from the registered state so a zero-wait memory
    // completes a byte per cycle; the PC register absorbs back-to-back incs.
    always_comb begin
        state_d         = state_q;
        opcode_en       = 1'b0;
        imm_en          = 1'b0;
        imm_d           = mem_rdata_in;
        pc_inc_out      = 1'b0;
        mem_req_out     = 1'b0;
        mem_addr_out    = 8'h00;
        instr_valid_out = 1'b0;
        if (!rst_in) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH_OP;
                end
                S_FETCH_OP: begin
                    mem_req_out  = 1'b1;
                    mem_addr_out = pc_in;
                    if (flush_in) begin
                        state_d = S_FETCH_OP;
                    end else if (mem_ready_in) begin
                        opcode_en  = 1'b1;
                        imm_en     = 1'b1;
                        imm_d      = 8'h00;
                        pc_inc_out = 1'b1;
                        state_d    = mem_rdata_in[IMM_FLAG_BIT] ? S_FETCH_IMM : S_ISSUE;
                    end else if (w_timeout) begin
                        state_d = S_FAULT;
                    end
                end
                S_FETCH_IMM: begin
                    mem_req_out  = 1'b1;
                    mem_addr_out = pc_in;
                    if (flush_in) begin
                        state_d = S_FETCH_OP;
                    end else if (mem_ready_in) begin
                        imm_en     = 1'b1;
                        pc_inc_out = 1'b1;
                        state_d    = S_ISSUE;
                    end else if (w_timeout) begin
                        state_d = S_FAULT;
                    end
                end
                S_ISSUE: begin
                    instr_valid_out = !flush_in;
                    if (flush_in || instr_ready_in) begin
                        state_d = S_FETCH_OP;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            opcode_q <= 8'h00;
            imm_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            if (opcode_en) begin
                opcode_q <= mem_rdata_in;
            end
            if (imm_en) begin
                imm_q <= imm_d;
            end
        end
    end

    assign instr_opcode_out = opcode_q;
    assign instr_imm_out    = imm_q;

`ifdef MINIBYTE_FETCH_TIMEOUT_EN
    logic w_waiting;

    assign w_waiting = !rst_in && !mem_ready_in && !flush_in &&
                       ((state_q == S_FETCH_OP) || (state_q == S_FETCH_IMM));

    minibyte_fetch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .wait_i    (w_waiting),
        .expired_o (w_timeout)
    );

    assign fault_out = (state_q == S_FAULT);
`else
    assign w_timeout = 1'b0;
    assign fault_out = 1'b0;

    // TIMEOUT_CYCLES only has meaning when the timer is built in.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_minibyte_fetch.sv
//------------------------------------------------------------------------------
// Module   : tb_minibyte_fetch
// Purpose  : Directed self-checking bench for minibyte_fetch.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_minibyte_fetch;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] pc_in;
    logic       pc_inc_out;
    logic [7:0] mem_addr_out;
    logic       mem_req_out;
    logic [7:0] mem_rdata_in;
    logic       mem_ready_in = 1'b0;
    logic       flush_in = 1'b0;
    logic [7:0] instr_opcode_out;
    logic [7:0] instr_imm_out;
    logic       instr_valid_out;
    logic       instr_ready_in = 1'b0;
    logic       fault_out;

    logic [7:0] mem [256];
    logic [7:0] pc_q = 8'h00;
    int         inc_cnt = 0;
    int         tests = 0;
    int         failed = 0;

    minibyte_fetch dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .pc_in            (pc_in),
        .pc_inc_out       (pc_inc_out),
        .mem_addr_out     (mem_addr_out),
        .mem_req_out      (mem_req_out),
        .mem_rdata_in     (mem_rdata_in),
        .mem_ready_in     (mem_ready_in),
        .flush_in         (flush_in),
        .instr_opcode_out (instr_opcode_out),
        .instr_imm_out    (instr_imm_out),
        .instr_valid_out  (instr_valid_out),
        .instr_ready_in   (instr_ready_in),
        .fault_out        (fault_out)
    );

    always #5 clk_in = ~clk_in;

    // Program counter register and program memory around the sequencer.
    always @(posedge clk_in) begin
        if (rst_in) pc_q <= 8'h00;
        else if (pc_inc_out) pc_q <= pc_q + 8'h01;
        if (pc_inc_out) inc_cnt <= inc_cnt + 1;
    end
    assign pc_in        = pc_q;
    assign mem_rdata_in = mem[mem_addr_out];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Leaves the bench in cycle 0: reset released, DUT in IDLE.
    task automatic do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_in = 1'b1; flush_in = 1'b0; mem_ready_in = 1'b0; instr_ready_in = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (pc_inc_out !== 1'b0) begin failed++; $display("FAIL reset_pc_inc: got %b expected 0", pc_inc_out); end
        tests++; if (mem_req_out !== 1'b0) begin failed++; $display("FAIL reset_req: got %b expected 0", mem_req_out); end
        tests++; if (mem_addr_out !== 8'h00) begin failed++; $display("FAIL reset_addr: got %h expected 00", mem_addr_out); end
        tests++; if (instr_opcode_out !== 8'h00) begin failed++; $display("FAIL reset_opcode: got %h expected 00", instr_opcode_out); end
        tests++; if (instr_imm_out !== 8'h00) begin failed++; $display("FAIL reset_imm: got %h expected 00", instr_imm_out); end
        tests++; if (instr_valid_out !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0", instr_valid_out); end
        tests++; if (fault_out !== 1'b0) begin failed++; $display("FAIL reset_fault: got %b expected 0", fault_out); end
    endtask

    task automatic test_one_byte();
        int base;
        do_reset();
        mem[0] = 8'h12;
        mem_ready_in = 1'b1;
        base = inc_cnt;
        #1;
        tests++; if (mem_req_out !== 1'b0) begin failed++; $display("FAIL one_idle_req: got %b expected 0", mem_req_out); end
        step();
        tests++; if ({mem_req_out, mem_addr_out, pc_inc_out} !== {1'b1, 8'h00, 1'b1}) begin
            failed++; $display("FAIL one_fetch: got req/addr/inc %b/%h/%b expected 1/00/1", mem_req_out, mem_addr_out, pc_inc_out); end
        step();
        tests++; if (instr_valid_out !== 1'b1) begin failed++; $display("FAIL one_valid_c2: got %b expected 1", instr_valid_out); end
        tests++; if ({instr_opcode_out, instr_imm_out} !== 16'h1200) begin
            failed++; $display("FAIL one_instr: got %h expected 1200", {instr_opcode_out, instr_imm_out}); end
        tests++; if ({mem_req_out, pc_inc_out} !== 2'b00) begin
            failed++; $display("FAIL one_issue_strobes: got %b expected 00", {mem_req_out, pc_inc_out}); end
        tests++; if (inc_cnt - base !== 1) begin failed++; $display("FAIL one_inc_count: got %0d expected 1", inc_cnt - base); end
        instr_ready_in = 1'b1;
        step();
        instr_ready_in = 1'b0;
        #1;
        tests++; if ({mem_req_out, mem_addr_out, instr_valid_out} !== {1'b1, 8'h01, 1'b0}) begin
            failed++; $display("FAIL one_next_fetch: got req/addr/valid %b/%h/%b expected 1/01/0", mem_req_out, mem_addr_out, instr_valid_out); end
    endtask

    task automatic test_two_byte_waits();
        int base;
        do_reset();
        mem[0] = 8'h85; mem[1] = 8'h3C;
        base = inc_cnt;
        step(); // cycle 1, wait
        tests++; if ({mem_req_out, mem_addr_out, pc_inc_out} !== {1'b1, 8'h00, 1'b0}) begin
            failed++; $display("FAIL two_wait_op: got req/addr/inc %b/%h/%b expected 1/00/0", mem_req_out, mem_addr_out, pc_inc_out); end
        step(); // cycle 2, wait
        step(); // cycle 3, ready
        mem_ready_in = 1'b1;
        #1;
        tests++; if ({mem_addr_out, pc_inc_out} !== {8'h00, 1'b1}) begin
            failed++; $display("FAIL two_op_accept: got addr/inc %h/%b expected 00/1", mem_addr_out, pc_inc_out); end
        step(); // cycle 4, FETCH_IMM wait
        mem_ready_in = 1'b0;
        #1;
        tests++; if ({mem_req_out, mem_addr_out, pc_inc_out, instr_valid_out} !== {1'b1, 8'h01, 1'b0, 1'b0}) begin
            failed++; $display("FAIL two_wait_imm: got req/addr/inc/valid %b/%h/%b/%b expected 1/01/0/0", mem_req_out, mem_addr_out, pc_inc_out, instr_valid_out); end
        step(); // cycle 5, wait
        step(); // cycle 6, ready
        mem_ready_in = 1'b1;
        #1;
        tests++; if ({mem_addr_out, pc_inc_out} !== {8'h01, 1'b1}) begin
            failed++; $display("FAIL two_imm_accept: got addr/inc %h/%b expected 01/1", mem_addr_out, pc_inc_out); end
        step(); // cycle 7, ISSUE
        tests++; if ({instr_valid_out, instr_opcode_out, instr_imm_out} !== {1'b1, 8'h85, 8'h3C}) begin
            failed++; $display("FAIL two_issue: got valid/op/imm %b/%h/%h expected 1/85/3c", instr_valid_out, instr_opcode_out, instr_imm_out); end
        tests++; if (inc_cnt - base !== 2) begin failed++; $display("FAIL two_inc_count: got %0d expected 2", inc_cnt - base); end
    endtask

    task automatic test_two_byte_zero_wait();
        do_reset();
        mem[0] = 8'h85; mem[1] = 8'h3C;
        mem_ready_in = 1'b1;
        step(); // cycle 1
        step(); // cycle 2
        tests++; if ({instr_valid_out, mem_addr_out, pc_inc_out} !== {1'b0, 8'h01, 1'b1}) begin
            failed++; $display("FAIL zw_c2: got valid/addr/inc %b/%h/%b expected 0/01/1", instr_valid_out, mem_addr_out, pc_inc_out); end
        step(); // cycle 3
        tests++; if ({instr_valid_out, instr_imm_out} !== {1'b1, 8'h3C}) begin
            failed++; $display("FAIL zw_c3: got valid/imm %b/%h expected 1/3c", instr_valid_out, instr_imm_out); end
    endtask

    task automatic test_back_to_back();
        logic       exp_v;
        logic [7:0] exp_op;
        logic [7:0] exp_imm;
        do_reset();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        mem_ready_in = 1'b1; instr_ready_in = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            exp_v = (c % 2 == 0);
            exp_op = 8'(c / 2);
            tests++; if (instr_valid_out !== exp_v) begin
                failed++; $display("FAIL b2b1_valid c%0d: got %b expected %b", c, instr_valid_out, exp_v); end
            if (exp_v) begin
                tests++; if (instr_opcode_out !== exp_op) begin
                    failed++; $display("FAIL b2b1_op c%0d: got %h expected %h", c, instr_opcode_out, exp_op); end
            end
        end
        do_reset();
        mem[0] = 8'h81; mem[1] = 8'hAA; mem[2] = 8'h82; mem[3] = 8'hBB;
        mem_ready_in = 1'b1; instr_ready_in = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            exp_v   = (c % 3 == 0);
            exp_op  = (c == 3) ? 8'h81 : 8'h82;
            exp_imm = (c == 3) ? 8'hAA : 8'hBB;
            tests++; if (instr_valid_out !== exp_v) begin
                failed++; $display("FAIL b2b2_valid c%0d: got %b expected %b", c, instr_valid_out, exp_v); end
            if (exp_v) begin
                tests++; if ({instr_opcode_out, instr_imm_out} !== {exp_op, exp_imm}) begin
                    failed++; $display("FAIL b2b2_instr c%0d: got %h%h expected %h%h", c, instr_opcode_out, instr_imm_out, exp_op, exp_imm); end
            end
        end
    endtask

    task automatic test_issue_stall();
        do_reset();
        mem[0] = 8'h12; mem[1] = 8'h34;
        mem_ready_in = 1'b1;
        step(); // cycle 1
        step(); // cycle 2, ISSUE
        for (int i = 0; i < 5; i++) begin
            tests++; if ({instr_valid_out, instr_opcode_out, instr_imm_out, mem_req_out, pc_inc_out} !== {1'b1, 8'h12, 8'h00, 1'b0, 1'b0}) begin
                failed++; $display("FAIL stall_hold %0d: got valid/op/imm/req/inc %b/%h/%h/%b/%b expected 1/12/00/0/0",
                                   i, instr_valid_out, instr_opcode_out, instr_imm_out, mem_req_out, pc_inc_out); end
            step();
        end
        instr_ready_in = 1'b1;
        #1;
        tests++; if (instr_valid_out !== 1'b1) begin failed++; $display("FAIL stall_handshake: got %b expected 1", instr_valid_out); end
        step();
        instr_ready_in = 1'b0;
        #1;
        tests++; if ({mem_req_out, mem_addr_out, instr_valid_out} !== {1'b1, 8'h01, 1'b0}) begin
            failed++; $display("FAIL stall_refetch: got req/addr/valid %b/%h/%b expected 1/01/0", mem_req_out, mem_addr_out, instr_valid_out); end
    endtask

    task automatic test_flush();
        do_reset();
        mem[0] = 8'h90; mem[1] = 8'h77;
        mem_ready_in = 1'b1;
        step(); // cycle 1, opcode 0x90 accepted
        step(); // cycle 2, FETCH_IMM with flush
        flush_in = 1'b1;
        #1;
        tests++; if ({pc_inc_out, instr_valid_out} !== 2'b00) begin
            failed++; $display("FAIL flush_imm: got inc/valid %b/%b expected 0/0", pc_inc_out, instr_valid_out); end
        step(); // cycle 3, back in FETCH_OP at pc 1
        flush_in = 1'b0;
        #1;
        tests++; if ({mem_req_out, mem_addr_out, pc_inc_out, instr_valid_out} !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
            failed++; $display("FAIL flush_refetch: got req/addr/inc/valid %b/%h/%b/%b expected 1/01/1/0", mem_req_out, mem_addr_out, pc_inc_out, instr_valid_out); end
        step(); // cycle 4, 0x77 is a 1-byte opcode fetched as an opcode
        tests++; if ({instr_valid_out, instr_opcode_out, instr_imm_out} !== {1'b1, 8'h77, 8'h00}) begin
            failed++; $display("FAIL flush_instr: got valid/op/imm %b/%h/%h expected 1/77/00", instr_valid_out, instr_opcode_out, instr_imm_out); end
        flush_in = 1'b1; instr_ready_in = 1'b1;
        #1;
        tests++; if (instr_valid_out !== 1'b0) begin failed++; $display("FAIL flush_issue_valid: got %b expected 0", instr_valid_out); end
        step();
        flush_in = 1'b0; instr_ready_in = 1'b0; mem_ready_in = 1'b0;
        #1;
        tests++; if ({mem_req_out, mem_addr_out} !== {1'b1, 8'h02}) begin
            failed++; $display("FAIL flush_issue_next: got req/addr %b/%h expected 1/02", mem_req_out, mem_addr_out); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        mem[0] = 8'h12; mem[1] = 8'h85;
        mem_ready_in = 1'b1; instr_ready_in = 1'b1;
        step(); // cycle 1
        step(); // cycle 2, handshake
        mem_ready_in = 1'b0; instr_ready_in = 1'b0;
        step(); // cycle 3, FETCH_OP wait at pc 1
        step(); // cycle 4, still waiting
        rst_in = 1'b1; mem_ready_in = 1'b1;
        #1;
        tests++; if (pc_inc_out !== 1'b0) begin failed++; $display("FAIL rst_cycle_inc: got %b expected 0", pc_inc_out); end
        step();
        rst_in = 1'b0; mem_ready_in = 1'b0;
        #1;
        tests++; if ({mem_req_out, mem_addr_out, pc_inc_out, instr_valid_out, instr_opcode_out, instr_imm_out} !== 27'd0) begin
            failed++; $display("FAIL rst_idle_outputs: got req/addr/inc/valid/op/imm %b/%h/%b/%b/%h/%h expected all 0",
                               mem_req_out, mem_addr_out, pc_inc_out, instr_valid_out, instr_opcode_out, instr_imm_out); end
        step();
        tests++; if ({mem_req_out, mem_addr_out} !== {1'b1, 8'h00}) begin
            failed++; $display("FAIL rst_refetch: got req/addr %b/%h expected 1/00", mem_req_out, mem_addr_out); end
    endtask

    task automatic test_timeout();
        do_reset();
        mem[0] = 8'h12;
        for (int c = 1; c <= 16; c++) step();
        tests++; if ({fault_out, mem_req_out} !== 2'b01) begin
            failed++; $display("FAIL timeout_c16: got fault/req %b/%b expected 0/1", fault_out, mem_req_out); end
`ifdef MINIBYTE_FETCH_TIMEOUT_EN
        step(); // cycle 17
        tests++; if ({fault_out, mem_req_out} !== 2'b10) begin
            failed++; $display("FAIL timeout_fault: got fault/req %b/%b expected 1/0", fault_out, mem_req_out); end
        mem_ready_in = 1'b1; flush_in = 1'b1;
        step(); step(); step();
        tests++; if ({fault_out, mem_req_out, pc_inc_out} !== 3'b100) begin
            failed++; $display("FAIL timeout_sticky: got fault/req/inc %b/%b/%b expected 1/0/0", fault_out, mem_req_out, pc_inc_out); end
        do_reset();
        tests++; if (fault_out !== 1'b0) begin failed++; $display("FAIL timeout_clear: got %b expected 0", fault_out); end
`else
        step(); step(); step(); step();
        tests++; if ({fault_out, mem_req_out, mem_addr_out} !== {1'b0, 1'b1, 8'h00}) begin
            failed++; $display("FAIL unbounded_wait: got fault/req/addr %b/%b/%h expected 0/1/00", fault_out, mem_req_out, mem_addr_out); end
        mem_ready_in = 1'b1;
        #1;
        tests++; if (pc_inc_out !== 1'b1) begin failed++; $display("FAIL unbounded_accept: got %b expected 1", pc_inc_out); end
`endif
    endtask

    initial begin
        test_reset();
        test_one_byte();
        test_two_byte_waits();
        test_two_byte_zero_wait();
        test_back_to_back();
        test_issue_stall();
        test_flush();
        test_reset_mid_fetch();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
